// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and sizing helpers for the synchronous FIFO
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy counter needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, one write port, one registered read port
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is deliberately left unreset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a read and write to the same slot return the old word.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered flags and sticky error status
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        wr,
  input  logic [WIDTH-1:0]            dataIn,
  input  logic                        rd,
  input  logic                        clr_err,
  output logic [WIDTH-1:0]            dataOut,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;
  logic          ovf_evt, udf_evt;
  logic [CW-1:0] count_next;

  // When full, a simultaneous read frees the slot the write lands in.
  assign rd_ok   = en & rd & ~empty;
  assign wr_ok   = en & wr & (~full | rd_ok);
  assign ovf_evt = en & wr & ~wr_ok;
  assign udf_evt = en & rd & empty;

  always_comb begin
    count_next = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_ok & ~rst),
    .waddr(wr_ptr),
    .wdata(dataIn),
    .re   (rd_ok & ~rst),
    .raddr(rd_ptr),
    .rdata(dataOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (en) begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CW'(DEPTH));
      almost_empty <= (count_next <= CW'(AE_LEVEL));
      almost_full  <= (count_next >= CW'(AF_LEVEL));
      // A fresh error in the clearing cycle keeps the flag set.
      overflow     <= (overflow & ~clr_err) | ovf_evt;
      underflow    <= (underflow & ~clr_err) | udf_evt;
    end
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in entries (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  global enable; 0 freezes all state.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port dataIn  input  WIDTH  write data, sampled with an accepted write.
REQ-010 SHALL have port rd  input  1  read request.
REQ-011 SHALL have port clr_err  input  1  clears sticky overflow/underflow.
REQ-012 SHALL have port dataOut  output  WIDTH  registered read data.
REQ-013 SHALL have port empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when en & wr & (!full | (rd & !empty)).
REQ-017 SHALL accept a read when en & rd & !empty.
REQ-018 SHALL, on full with rd & wr, accept both; count unchanged, oldest word out, new word stored.
REQ-019 SHALL, on empty with rd & wr, accept the write only; no fall-through; underflow set.
REQ-020 SHALL present the word read at an accepted read on dataOut one cycle later; dataOut holds otherwise.
REQ-021 SHALL preserve FIFO order; read/write pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-022 SHALL update count by +1 (write only), -1 (read only), 0 (both or neither).
REQ-023 SHALL register all flags so they reflect the post-edge count: empty=(count==0), full=(count==DEPTH), almost_empty=(count<=AE_LEVEL), almost_full=(count>=AF_LEVEL).
REQ-024 SHALL set overflow on en & wr rejected (full, no accepted read); the data is dropped and state is unchanged.
REQ-025 SHALL set underflow on en & rd while empty; dataOut holds.
REQ-026 SHALL clear overflow/underflow on clr_err; a new error in the same cycle sets the flag (set wins).
REQ-027 SHALL, with en=0, ignore rd, wr and clr_err; all outputs hold.

Reset
REQ-028 SHALL give rst priority over en and all requests.
REQ-029 SHALL on rst clear pointers and count and force dataOut=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-030 SHALL on rst mid-operation discard all stored words; storage array contents need not be cleared.
REQ-031 SHALL be usable the cycle after rst deasserts.

Structure
REQ-032 SHALL place the default WIDTH/DEPTH constants and the count-width helper function in shared package fifo_pkg.
REQ-033 SHALL implement storage in sub-module fifo_mem (DEPTH x WIDTH array, one write port, one registered read port); control, pointers and flags stay in sync_fifo.

Verification (WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 SHALL cover: rst then en=1, write 0x0..0x7 on 8 consecutive cycles -> full=1 after 8th edge, almost_full=1 after 6th, count=8.
REQ-035 SHALL cover: from full, rd=1 for 8 cycles -> dataOut 0x0..0x7 one cycle after each read, empty=1, count=0.
REQ-036 SHALL cover: full, wr=1 with dataIn=0xA, rd=0 -> overflow=1, count=8, next 8 reads return 0x0..0x7 only.
REQ-037 SHALL cover: empty, rd=1 & wr=1 with dataIn=0x5 -> underflow=1, count=1, next read returns 0x5.
REQ-038 SHALL cover: full, rd=1 & wr=1 with dataIn=0x8 for 4 cycles (writes 0x8..0xB) -> count=8, pointers wrap, drain yields 0x4..0xB.
REQ-039 SHALL cover: 3 words stored, rst=1 for one cycle -> empty=1, count=0, dataOut=0; en=0 with wr=1 -> no state change.
